// File: rtl/reg_scoreboard_if.sv
// Issue/retire interface between instruction decode, writeback and the register scoreboard.
// The master side (decode/writeback) drives the requests, and the slave side (scoreboard) answers.
interface reg_scoreboard_if #(
  parameter int REG_W = 5,
  parameter int NREGS = 2**REG_W
);
  logic             iss_valid;
  logic [REG_W-1:0] iss_rs1;
  logic [REG_W-1:0] iss_rs2;
  logic [REG_W-1:0] iss_rd;
  logic             iss_use_rs1;
  logic             iss_use_rs2;
  logic             iss_use_rdsrc;
  logic             iss_wr_rd;
  logic             iss_ready;
  logic             ret_valid;
  logic [REG_W-1:0] ret_rd;
  logic             flush;
  logic [NREGS-1:0] busy;
  logic             pending_any;
  logic             err_underflow;

  modport master (
    output iss_valid, iss_rs1, iss_rs2, iss_rd,
           iss_use_rs1, iss_use_rs2, iss_use_rdsrc, iss_wr_rd,
           ret_valid, ret_rd, flush,
    input  iss_ready, busy, pending_any, err_underflow
  );

  modport slave (
    input  iss_valid, iss_rs1, iss_rs2, iss_rd,
           iss_use_rs1, iss_use_rs2, iss_use_rdsrc, iss_wr_rd,
           ret_valid, ret_rd, flush,
    output iss_ready, busy, pending_any, err_underflow
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register-file hazard scoreboard: one pending-write counter per architectural register.
// Issue is granted only when no used source has a write still outstanding.
module reg_scoreboard #(
  parameter int REG_W = 5,
  parameter int NREGS = 2**REG_W,
  parameter int CNT_W = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  reg_scoreboard_if.slave        sb
);

  localparam logic [CNT_W-1:0] MAX_PEND = {CNT_W{1'b1}};
  localparam logic [REG_W-1:0] ZERO_REG = '0;

  logic [CNT_W-1:0] cnt      [NREGS];
  logic [CNT_W-1:0] cnt_next [NREGS];
  logic             err_q;

  logic raw_rs1, raw_rs2, raw_rdsrc;
  logic raw_hazard;
  logic struct_hazard;
  logic ready;
  logic fire;
  logic inc;
  logic dec;
  logic underflow;

  // Hazards look only at registered counters, so a same-cycle retire never
  // bypasses into the grant; the dependent instruction is released one cycle later.
  always_comb begin
    raw_rs1       = sb.iss_use_rs1   && (sb.iss_rs1 != ZERO_REG) && (cnt[sb.iss_rs1] != '0);
    raw_rs2       = sb.iss_use_rs2   && (sb.iss_rs2 != ZERO_REG) && (cnt[sb.iss_rs2] != '0);
    raw_rdsrc     = sb.iss_use_rdsrc && (sb.iss_rd  != ZERO_REG) && (cnt[sb.iss_rd]  != '0);
    raw_hazard    = raw_rs1 || raw_rs2 || raw_rdsrc;
    struct_hazard = sb.iss_wr_rd && (sb.iss_rd != ZERO_REG) && (cnt[sb.iss_rd] == MAX_PEND);
    ready         = !reset && !sb.flush && !raw_hazard && !struct_hazard;
    fire          = sb.iss_valid && ready;
    inc           = fire && sb.iss_wr_rd && (sb.iss_rd != ZERO_REG);
    dec           = sb.ret_valid && (sb.ret_rd != ZERO_REG) && (cnt[sb.ret_rd] != '0);
    underflow     = sb.ret_valid && (sb.ret_rd != ZERO_REG) && (cnt[sb.ret_rd] == '0);
  end

  // NOTE: every combinational output gets its default before any conditional
  // update, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      cnt_next[i] = cnt[i];
      if (i != 0) begin
        case ({inc && (sb.iss_rd == REG_W'(i)), dec && (sb.ret_rd == REG_W'(i))})
          2'b10:   cnt_next[i] = cnt[i] + CNT_W'(1);
          2'b01:   cnt_next[i] = cnt[i] - CNT_W'(1);
          default: cnt_next[i] = cnt[i];
        endcase
      end
    end
  end

  // NOTE: the counter array is hazard state rather than data storage, so every
  // entry is cleared on reset; sequential state is written with <= only.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) cnt[i] <= '0;
      err_q <= 1'b0;
    end else begin
      if (sb.flush) begin
        for (int i = 0; i < NREGS; i++) cnt[i] <= '0;
      end else begin
        for (int i = 0; i < NREGS; i++) cnt[i] <= cnt_next[i];
      end
      if (underflow) err_q <= 1'b1;
    end
  end

  always_comb begin
    sb.busy = '0;
    for (int i = 1; i < NREGS; i++) sb.busy[i] = (cnt[i] != '0);
    sb.pending_any   = |sb.busy;
    sb.iss_ready     = ready;
    sb.err_underflow = err_q;
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard. Inputs change just after the falling edge; the
// combinational grant is sampled 1 ns later, and state is sampled at the next falling edge.
module tb_reg_scoreboard;
  localparam int REG_W = 5;
  localparam int NREGS = 32;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  reg_scoreboard_if #(.REG_W(REG_W), .NREGS(NREGS)) sb_if ();

  reg_scoreboard #(.REG_W(REG_W), .NREGS(NREGS), .CNT_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    sb_if.iss_valid     = 1'b0;
    sb_if.iss_rs1       = '0;
    sb_if.iss_rs2       = '0;
    sb_if.iss_rd        = '0;
    sb_if.iss_use_rs1   = 1'b0;
    sb_if.iss_use_rs2   = 1'b0;
    sb_if.iss_use_rdsrc = 1'b0;
    sb_if.iss_wr_rd     = 1'b0;
    sb_if.ret_valid     = 1'b0;
    sb_if.ret_rd        = '0;
    sb_if.flush         = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                       input logic u2, input logic [4:0] rd, input logic urd, input logic wr);
    sb_if.iss_valid     = 1'b1;
    sb_if.iss_rs1       = rs1;
    sb_if.iss_use_rs1   = u1;
    sb_if.iss_rs2       = rs2;
    sb_if.iss_use_rs2   = u2;
    sb_if.iss_rd        = rd;
    sb_if.iss_use_rdsrc = urd;
    sb_if.iss_wr_rd     = wr;
  endtask

  task automatic retire(input logic [4:0] rd);
    sb_if.ret_valid = 1'b1;
    sb_if.ret_rd    = rd;
  endtask

  // Advance one clock: passes a rising edge, lands on the following falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    issue(5'd1, 1'b0, 5'd0, 1'b0, 5'd2, 1'b0, 1'b1);
    step();
    #1 check("ready_in_reset", 32'(sb_if.iss_ready), 32'd0);
    step();
    reset = 1'b0;
    idle();
    #1;
    check("reset_busy", sb_if.busy, 32'h0);
    check("reset_pending", 32'(sb_if.pending_any), 32'd0);
    check("reset_err", 32'(sb_if.err_underflow), 32'd0);

    // Basic RAW: write r5, dependent read stalls until the cycle after retire.
    step();
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b0, 1'b1);
    #1 check("r5_writer_ready", 32'(sb_if.iss_ready), 32'd1);
    step(); idle();
    check("busy5_set", 32'(sb_if.busy[5]), 32'd1);
    issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1 check("raw5_stall", 32'(sb_if.iss_ready), 32'd0);
    retire(5'd5);
    #1 check("raw5_no_bypass", 32'(sb_if.iss_ready), 32'd0);
    step();
    sb_if.ret_valid = 1'b0;
    #1 check("raw5_released", 32'(sb_if.iss_ready), 32'd1);
    check("busy5_clear", 32'(sb_if.busy[5]), 32'd0);
    step(); idle();

    // Register 0 is never tracked.
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    #1 check("r0_writer_ready", 32'(sb_if.iss_ready), 32'd1);
    step(); idle();
    check("r0_busy", sb_if.busy, 32'h0);
    check("r0_pending", 32'(sb_if.pending_any), 32'd0);
    issue(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
    #1 check("r0_reader_ready", 32'(sb_if.iss_ready), 32'd1);
    step(); idle();

    // Three writers to r7 saturate the counter; the fourth waits for one retire.
    for (int k = 0; k < 3; k++) begin
      issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b0, 1'b1);
      #1 check($sformatf("r7_writer%0d_ready", k), 32'(sb_if.iss_ready), 32'd1);
      step(); idle();
    end
    check("r7_busy_saturated", sb_if.busy, 32'h0000_0080);
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b0, 1'b1);
    #1 check("r7_struct_stall", 32'(sb_if.iss_ready), 32'd0);
    retire(5'd7);
    #1 check("r7_struct_no_bypass", 32'(sb_if.iss_ready), 32'd0);
    step();
    sb_if.ret_valid = 1'b0;
    #1 check("r7_fourth_fires", 32'(sb_if.iss_ready), 32'd1);
    step(); idle();
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b0, 1'b1);
    #1 check("r7_full_again", 32'(sb_if.iss_ready), 32'd0);
    idle();
    for (int k = 0; k < 3; k++) begin
      #1 check($sformatf("r7_drain%0d_busy", k), 32'(sb_if.busy[7]), 32'd1);
      retire(5'd7);
      step(); idle();
    end
    check("r7_drained", 32'(sb_if.busy[7]), 32'd0);

    // Same-cycle issue and retire on r9 leave its count at 1.
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b0, 1'b1);
    step();
    retire(5'd9);
    #1 check("r9_second_ready", 32'(sb_if.iss_ready), 32'd1);
    step(); idle();
    check("r9_still_busy", 32'(sb_if.busy[9]), 32'd1);
    retire(5'd9);
    step(); idle();
    check("r9_one_retire_clears", 32'(sb_if.busy[9]), 32'd0);
    check("r9_no_underflow", 32'(sb_if.err_underflow), 32'd0);

    // Retire to r0 is ignored; retire to an idle r12 raises the sticky error.
    retire(5'd0);
    step(); idle();
    check("r0_retire_no_err", 32'(sb_if.err_underflow), 32'd0);
    retire(5'd12);
    #1 check("r12_err_not_yet", 32'(sb_if.err_underflow), 32'd0);
    step(); idle();
    check("r12_underflow", 32'(sb_if.err_underflow), 32'd1);
    check("r12_stays_idle", 32'(sb_if.busy[12]), 32'd0);

    // Flush with a valid issue pending: no grant, everything clears, error stays.
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b0, 1'b1);
    step();
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b0, 1'b1);
    step(); idle();
    check("r3_r4_busy", sb_if.busy, 32'h0000_0018);
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b0, 1'b1);
    sb_if.flush = 1'b1;
    retire(5'd3);
    #1 check("flush_blocks_issue", 32'(sb_if.iss_ready), 32'd0);
    step(); idle();
    check("flush_busy", sb_if.busy, 32'h0);
    check("flush_pending", 32'(sb_if.pending_any), 32'd0);
    check("flush_keeps_err", 32'(sb_if.err_underflow), 32'd1);

    // Store reads rd as data; an immediate form ignores its rs2 field.
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b0, 1'b1);
    step(); idle();
    issue(5'd1, 1'b1, 5'd6, 1'b0, 5'd2, 1'b0, 1'b1);
    #1 check("imm_ignores_rs2", 32'(sb_if.iss_ready), 32'd1);
    step(); idle();
    issue(5'd1, 1'b1, 5'd2, 1'b0, 5'd6, 1'b1, 1'b0);
    #1 check("store_rdsrc_stall", 32'(sb_if.iss_ready), 32'd0);
    idle();
    retire(5'd6);
    step(); idle();
    check("pending_r2_only", sb_if.busy, 32'h0000_0004);
    issue(5'd1, 1'b1, 5'd2, 1'b0, 5'd6, 1'b1, 1'b0);
    #1 check("store_released", 32'(sb_if.iss_ready), 32'd1);
    step(); idle();

    // Mid-operation reset clears counters and the error; later retires underflow.
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b0, 1'b1);
    step(); idle();
    reset = 1'b1;
    retire(5'd10);
    step(); idle();
    reset = 1'b0;
    #1;
    check("midreset_busy", sb_if.busy, 32'h0);
    check("midreset_err", 32'(sb_if.err_underflow), 32'd0);
    retire(5'd10);
    step(); idle();
    check("post_reset_underflow", 32'(sb_if.err_underflow), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
